// File: rtl/td4_core_param.sv
// TD4-style 4-bit-ISA CPU core with a parametrised datapath, carry flag and RUN/HALT control.
// Instruction fetch is external and combinational: opcode/immediate correspond to pc_out.
module td4_core_param #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] io_input,
  output logic [DATA_W-1:0] regA_o,
  output logic [DATA_W-1:0] regB_o,
  output logic [DATA_W-1:0] regOut,
  output logic [PC_W-1:0]   pc_out,
  output logic              carry,
  output logic              halted
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_ADD_B = 4'b1010;
  localparam logic [3:0] OP_MOV_A = 4'b1100;
  localparam logic [3:0] OP_MOV_B = 4'b1110;
  localparam logic [3:0] OP_MOV_AB = 4'b1000;
  localparam logic [3:0] OP_MOV_BA = 4'b0010;
  localparam logic [3:0] OP_IN_A  = 4'b0100;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1101;
  localparam logic [3:0] OP_JMP   = 4'b1111;
  localparam logic [3:0] OP_JNC   = 4'b0111;
  localparam logic [3:0] OP_HLT   = 4'b0001;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            state_q, state_n;
  logic [DATA_W-1:0] a_q, a_n, b_q, b_n, out_q, out_n;
  logic [PC_W-1:0]   pc_q, pc_n;
  logic              carry_q, carry_n;

  logic [DATA_W:0]   sum_a, sum_b;
  logic [PC_W-1:0]   jmp_target;

  assign sum_a      = {1'b0, a_q} + {1'b0, immediate};
  assign sum_b      = {1'b0, b_q} + {1'b0, immediate};
  // Zero-extends or truncates the immediate to the address width.
  assign jmp_target = PC_W'(immediate);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      out_q   <= out_n;
      pc_q    <= pc_n;
      carry_q <= carry_n;
    end
  end

  // Execute one instruction per enabled edge while running.
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    out_n   = out_q;
    pc_n    = pc_q;
    carry_n = carry_q;
    if (state_q == ST_RUN && ce) begin
      pc_n    = pc_q + PC_W'(1);
      carry_n = 1'b0;
      case (opcode)
        OP_ADD_A:  begin a_n = sum_a[DATA_W-1:0]; carry_n = sum_a[DATA_W]; end
        OP_ADD_B:  begin b_n = sum_b[DATA_W-1:0]; carry_n = sum_b[DATA_W]; end
        OP_MOV_A:  a_n = immediate;
        OP_MOV_B:  b_n = immediate;
        OP_MOV_AB: a_n = b_q;
        OP_MOV_BA: b_n = a_q;
        OP_IN_A:   a_n = io_input;
        OP_IN_B:   b_n = io_input;
        OP_OUT_B:  out_n = b_q;
        OP_OUT_IM: out_n = immediate;
        OP_JMP:    pc_n = jmp_target;
        OP_JNC:    if (!carry_q) pc_n = jmp_target;
        OP_HLT:    state_n = ST_HALT;
        default:   ;
      endcase
    end
  end

  assign regA_o = a_q;
  assign regB_o = b_q;
  assign regOut = out_q;
  assign pc_out = pc_q;
  assign carry  = carry_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4_core_param.sv
// Directed bench for td4_core_param: default 4/4 instance plus an 8/6 parameter instance.
module tb_td4_core_param;

  logic       clk = 1'b0;
  logic       rst_n, ce;
  logic [3:0] opcode;
  logic [3:0] imm4, io4;
  logic [7:0] imm8, io8;
  logic [3:0] a4, b4, o4, pc4;
  logic       c4, h4;
  logic [7:0] a8, b8, o8;
  logic [5:0] pc8;
  logic       c8, h8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  td4_core_param u4 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .opcode(opcode), .immediate(imm4), .io_input(io4),
    .regA_o(a4), .regB_o(b4), .regOut(o4), .pc_out(pc4), .carry(c4), .halted(h4)
  );

  td4_core_param #(.DATA_W(8), .PC_W(6)) u8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .opcode(opcode), .immediate(imm8), .io_input(io8),
    .regA_o(a8), .regB_o(b8), .regOut(o8), .pc_out(pc8), .carry(c8), .halted(h8)
  );

  task automatic step(input logic [3:0] op, input logic [7:0] im);
    opcode = op;
    imm4   = im[3:0];
    imm8   = im;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(4'b0000, 8'd5);
    step(4'b0000, 8'd5);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ce = 1'b1;
    io4 = 4'd0;
    io8 = 8'd0;
    do_reset();
    tests++; if (a4 !== 4'd0)  begin fails++; $display("FAIL reset_a got %0d want 0", a4); end
    tests++; if (b4 !== 4'd0)  begin fails++; $display("FAIL reset_b got %0d want 0", b4); end
    tests++; if (o4 !== 4'd0)  begin fails++; $display("FAIL reset_out got %0d want 0", o4); end
    tests++; if (pc4 !== 4'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", pc4); end
    tests++; if (c4 !== 1'b0)  begin fails++; $display("FAIL reset_carry got %0b want 0", c4); end
    tests++; if (h4 !== 1'b0)  begin fails++; $display("FAIL reset_halted got %0b want 0", h4); end
    step(4'b0000, 8'd5);
    tests++; if (a4 !== 4'd5)  begin fails++; $display("FAIL first_add_a got %0d want 5", a4); end
    tests++; if (pc4 !== 4'd1) begin fails++; $display("FAIL first_add_pc got %0d want 1", pc4); end
  endtask

  task automatic test_carry_jnc();
    do_reset();
    step(4'b1100, 8'd12);
    step(4'b0000, 8'd5);
    tests++; if (a4 !== 4'd1)  begin fails++; $display("FAIL add_wrap_a got %0d want 1", a4); end
    tests++; if (c4 !== 1'b1)  begin fails++; $display("FAIL add_carry got %0b want 1", c4); end
    step(4'b0111, 8'd0);
    tests++; if (pc4 !== 4'd3) begin fails++; $display("FAIL jnc_not_taken_pc got %0d want 3", pc4); end
    tests++; if (c4 !== 1'b0)  begin fails++; $display("FAIL jnc_clears_carry got %0b want 0", c4); end
    step(4'b0111, 8'd0);
    tests++; if (pc4 !== 4'd0) begin fails++; $display("FAIL jnc_taken_pc got %0d want 0", pc4); end
    step(4'b1110, 8'd14);
    step(4'b1010, 8'd3);
    tests++; if (b4 !== 4'd1 || c4 !== 1'b1) begin fails++; $display("FAIL add_b got b=%0d c=%0b want b=1 c=1", b4, c4); end
  endtask

  task automatic test_io_mov();
    do_reset();
    io4 = 4'd9;
    step(4'b0110, 8'd0);
    tests++; if (b4 !== 4'd9) begin fails++; $display("FAIL in_b got %0d want 9", b4); end
    step(4'b1000, 8'd0);
    tests++; if (a4 !== 4'd9) begin fails++; $display("FAIL mov_a_b got %0d want 9", a4); end
    step(4'b1001, 8'd0);
    tests++; if (o4 !== 4'd9) begin fails++; $display("FAIL out_b got %0d want 9", o4); end
    step(4'b1101, 8'd6);
    tests++; if (o4 !== 4'd6) begin fails++; $display("FAIL out_im got %0d want 6", o4); end
    step(4'b1110, 8'd3);
    step(4'b0010, 8'd0);
    tests++; if (b4 !== 4'd9 || a4 !== 4'd9) begin fails++; $display("FAIL mov_b_a got a=%0d b=%0d want a=9 b=9", a4, b4); end
    io4 = 4'd4;
    step(4'b0100, 8'd0);
    step(4'b1110, 8'd11);
    step(4'b1000, 8'd0);
    tests++; if (a4 !== 4'd11) begin fails++; $display("FAIL in_a_then_mov got %0d want 11", a4); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step(4'b1111, 8'd14);
    tests++; if (pc4 !== 4'd14) begin fails++; $display("FAIL jmp14 got %0d want 14", pc4); end
    step(4'b0011, 8'd0);
    tests++; if (pc4 !== 4'd15) begin fails++; $display("FAIL nop_pc15 got %0d want 15", pc4); end
    step(4'b0101, 8'd0);
    tests++; if (pc4 !== 4'd0)  begin fails++; $display("FAIL wrap_pc0 got %0d want 0", pc4); end
    step(4'b1011, 8'd0);
    tests++; if (pc4 !== 4'd1)  begin fails++; $display("FAIL nop_pc1 got %0d want 1", pc4); end
    step(4'b1111, 8'd10);
    tests++; if (pc4 !== 4'd10) begin fails++; $display("FAIL jmp10 got %0d want 10", pc4); end
  endtask

  task automatic test_ce_hlt();
    do_reset();
    ce = 1'b0;
    repeat (3) step(4'b0000, 8'd1);
    tests++; if (a4 !== 4'd0 || pc4 !== 4'd0) begin fails++; $display("FAIL ce0_hold got a=%0d pc=%0d want 0 0", a4, pc4); end
    ce = 1'b1;
    step(4'b0000, 8'd1);
    step(4'b0000, 8'd15);
    ce = 1'b0;
    repeat (3) step(4'b1111, 8'd0);
    tests++; if (pc4 !== 4'd2 || c4 !== 1'b1 || a4 !== 4'd0) begin fails++; $display("FAIL ce0_flag_hold got pc=%0d c=%0b a=%0d want 2 1 0", pc4, c4, a4); end
    ce = 1'b1;
    step(4'b1100, 8'd7);
    step(4'b0000, 8'd9);
    tests++; if (pc4 !== 4'd4 || c4 !== 1'b1) begin fails++; $display("FAIL pre_hlt got pc=%0d c=%0b want 4 1", pc4, c4); end
    step(4'b0001, 8'd0);
    tests++; if (pc4 !== 4'd5 || h4 !== 1'b1 || c4 !== 1'b0) begin fails++; $display("FAIL hlt got pc=%0d h=%0b c=%0b want 5 1 0", pc4, h4, c4); end
    repeat (5) step(4'b0000, 8'd1);
    tests++; if (a4 !== 4'd0 || pc4 !== 4'd5 || h4 !== 1'b1) begin fails++; $display("FAIL halt_frozen got a=%0d pc=%0d h=%0b want 0 5 1", a4, pc4, h4); end
    ce = 1'b0;
    rst_n = 1'b0;
    step(4'b0000, 8'd1);
    rst_n = 1'b1;
    tests++; if (pc4 !== 4'd0 || h4 !== 1'b0) begin fails++; $display("FAIL reset_exits_halt got pc=%0d h=%0b want 0 0", pc4, h4); end
    ce = 1'b1;
  endtask

  task automatic test_wide();
    do_reset();
    step(4'b1100, 8'd200);
    step(4'b0000, 8'd100);
    tests++; if (a8 !== 8'd44 || c8 !== 1'b1) begin fails++; $display("FAIL wide_add got a=%0d c=%0b want 44 1", a8, c8); end
    step(4'b1111, 8'd63);
    tests++; if (pc8 !== 6'd63 || c8 !== 1'b0) begin fails++; $display("FAIL wide_jmp63 got pc=%0d c=%0b want 63 0", pc8, c8); end
    step(4'b0011, 8'd0);
    tests++; if (pc8 !== 6'd0) begin fails++; $display("FAIL wide_wrap got %0d want 0", pc8); end
    step(4'b1111, 8'd255);
    tests++; if (pc8 !== 6'd63) begin fails++; $display("FAIL wide_jmp_trunc got %0d want 63", pc8); end
    io8 = 8'd170;
    step(4'b0110, 8'd0);
    step(4'b1001, 8'd0);
    tests++; if (o8 !== 8'd170 || b8 !== 8'd170) begin fails++; $display("FAIL wide_io got out=%0d b=%0d want 170 170", o8, b8); end
    tests++; if (h8 !== 1'b0) begin fails++; $display("FAIL wide_halted got %0b want 0", h8); end
  endtask

  initial begin
    rst_n  = 1'b0;
    ce     = 1'b1;
    opcode = 4'b0000;
    imm4   = 4'd0;
    imm8   = 8'd0;
    io4    = 4'd0;
    io8    = 8'd0;
    test_reset();
    test_carry_jnc();
    test_io_mov();
    test_pc_wrap();
    test_ce_hlt();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
